// File: rtl/z80_ld_pkg.sv
// z80_ld_pkg: state encoding and parameter limits shared by the LD (nn) transfer sequencer.
package z80_ld_pkg;

    // Sequencer phases: wait for a request, move bytes over the bus, signal completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    // Legal range for the MAX_BYTES parameter (LD A,(nn) up to a 32-bit transfer).
    localparam int MAX_BYTES_MIN = 1;
    localparam int MAX_BYTES_MAX = 4;

    // Width of the nbytes request field.
    localparam int NBYTES_W = 3;

    // A zero or oversized byte count is treated as the largest transfer the instance supports.
    function automatic logic [NBYTES_W-1:0] clamp_nbytes(
        input logic [NBYTES_W-1:0] nb,
        input logic [NBYTES_W-1:0] max_nb
    );
        if (nb == '0 || nb > max_nb) begin
            return max_nb;
        end
        return nb;
    endfunction

endpackage

// File: rtl/z80_ld_ind_nn_seq.sv
// z80_ld_ind_nn_seq: byte-serial bus sequencer for the Z80 absolute-address
// loads and stores LD A,(nn) / LD rr,(nn) / LD (nn),rr. Bytes move little-endian
// from address nn upward, wrapping at the top of the address space.
module z80_ld_ind_nn_seq
    import z80_ld_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int MAX_BYTES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   store,
    input  logic [2:0]             nbytes,
    input  logic [ADDR_W-1:0]      nn,
    input  logic [8*MAX_BYTES-1:0] wdata,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [7:0]             mem_wdata,
    input  logic                   mem_ack,
    input  logic [7:0]             mem_rdata,
    output logic                   busy,
    output logic                   done,
    output logic [8*MAX_BYTES-1:0] rdata
);

    // Byte lanes are rounded up to a power of two so the byte index selects a lane exactly.
    localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int NLANE = 1 << IDX_W;
    localparam logic [NBYTES_W-1:0] MAX_NB = NBYTES_W'(MAX_BYTES);

    if (MAX_BYTES < MAX_BYTES_MIN || MAX_BYTES > MAX_BYTES_MAX) begin : g_bad_max_bytes
        $error("z80_ld_ind_nn_seq: MAX_BYTES must be within 1..4");
    end

    state_e                 state_q,     state_d;
    logic                   store_q,     store_d;
    logic [IDX_W-1:0]       last_q,      last_d;
    logic [IDX_W-1:0]       k_q,         k_d;
    logic [NLANE-1:0][7:0]  wdata_q,     wdata_d;
    logic [NLANE-1:0][7:0]  rdata_q,     rdata_d;
    logic                   mem_req_q,   mem_req_d;
    logic                   mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q,  mem_addr_d;
    logic [7:0]             mem_wdata_q, mem_wdata_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;

    logic [NBYTES_W-1:0]    nbytes_eff;
    logic [IDX_W-1:0]       k_next;

    // Next-state and next-output logic for the whole sequencer.
    always_comb begin
        // NOTE: every _d signal takes its held value first, so no branch can leave one
        // unassigned and infer a latch.
        state_d     = state_q;
        store_d     = store_q;
        last_d      = last_q;
        k_d         = k_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        nbytes_eff  = clamp_nbytes(nbytes, MAX_NB);
        k_next      = k_q + IDX_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d              = XFER;
                    store_d              = store;
                    last_d               = IDX_W'(nbytes_eff - 3'd1);
                    k_d                  = '0;
                    wdata_d              = '0;
                    wdata_d[MAX_BYTES-1:0] = wdata;
                    rdata_d              = '0;
                    mem_req_d            = 1'b1;
                    mem_we_d             = store;
                    mem_addr_d           = nn;
                    mem_wdata_d          = store ? wdata[7:0] : 8'h00;
                    busy_d               = 1'b1;
                end
            end

            XFER: begin
                // The bus outputs are registers, so they simply hold through wait states.
                if (mem_ack) begin
                    if (!store_q) begin
                        rdata_d[k_q] = mem_rdata;
                    end
                    if (k_q == last_q) begin
                        state_d     = DONE;
                        mem_req_d   = 1'b0;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = 8'h00;
                        done_d      = 1'b1;
                    end else begin
                        k_d         = k_next;
                        mem_addr_d  = mem_addr_q + ADDR_W'(1);
                        mem_wdata_d = store_q ? wdata_q[k_next] : 8'h00;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, bus outputs and assembled load data, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the values from before the edge.
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Request fields captured at start; only read while a transfer is in flight.
    always_ff @(posedge clk) begin
        // NOTE: these captured fields are deliberately left out of reset: they are
        // always reloaded on an accepted start before anything reads them.
        store_q <= store_d;
        last_q  <= last_d;
        wdata_q <= wdata_d;
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rdata     = rdata_q[MAX_BYTES-1:0];

endmodule

// File: tb/tb_z80_ld_ind_nn_seq.sv
// tb_z80_ld_ind_nn_seq: scoreboard bench for the LD (nn) sequencer. Stimulus
// queues the expected bus beats and completion data from a byte-array memory
// model; monitors compare them as the DUT presents them. A wait-state memory
// responder serves the bus.
module tb_z80_ld_ind_nn_seq;

    localparam int ADDR_W = 16;
    localparam int MAXB   = 4;
    localparam int DW     = 8 * MAXB;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [7:0]        wdata;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              store;
    logic [2:0]        nbytes;
    logic [ADDR_W-1:0] nn;
    logic [DW-1:0]     wdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              busy;
    logic              done;
    logic [DW-1:0]     rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] bus_mem [65536];
    logic [7:0] ref_mem [65536];

    beat_t         exp_beats [$];
    logic [DW-1:0] exp_rdata [$];

    int fixed_wait = 0;
    bit ack_noise  = 1'b0;
    int remaining  = -1;

    z80_ld_ind_nn_seq #(
        .ADDR_W   (ADDR_W),
        .MAX_BYTES(MAXB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .store    (store),
        .nbytes   (nbytes),
        .nn       (nn),
        .wdata    (wdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string msg);
        total++;
        bad++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    task automatic set_mem(input logic [ADDR_W-1:0] a, input logic [7:0] v);
        bus_mem[a] = v;
        ref_mem[a] = v;
    endtask

    // Memory responder: programmable wait states per byte, random acks while idle.
    always @(posedge clk) begin
        #1;
        if (mem_req === 1'b1) begin
            if (remaining < 0) begin
                remaining = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
            end
            if (remaining == 0) begin
                mem_ack   = 1'b1;
                remaining = -1;
                mem_rdata = bus_mem[mem_addr];
                if (mem_we === 1'b1) bus_mem[mem_addr] = mem_wdata;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
                remaining--;
            end
        end else begin
            remaining = -1;
            mem_ack   = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = 8'($urandom);
        end
    end

    // Bus monitor: stability during wait states and each completed beat against the queue.
    logic              prev_req = 1'b0;
    logic              prev_ack = 1'b0;
    logic              prev_we  = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [7:0]        prev_wd  = '0;

    always @(negedge clk) begin
        beat_t b;
        if (prev_req === 1'b1 && prev_ack !== 1'b1) begin
            check("req_held", mem_req, 1);
            if (mem_req === 1'b1) begin
                check("addr_stable", mem_addr, prev_addr);
                check("we_stable", mem_we, prev_we);
                check("wdata_stable", mem_wdata, prev_wd);
            end
        end
        if (mem_req === 1'b1 && mem_ack === 1'b1) begin
            if (exp_beats.size() == 0) begin
                fail_now("unexpected_beat", $sformatf("addr 0x%0h with nothing expected", mem_addr));
            end else begin
                b = exp_beats.pop_front();
                check("beat_addr", mem_addr, b.addr);
                check("beat_we", mem_we, b.we);
                check("beat_wdata", mem_wdata, b.wdata);
            end
        end
        prev_req  = mem_req;
        prev_ack  = mem_ack;
        prev_we   = mem_we;
        prev_addr = mem_addr;
        prev_wd   = mem_wdata;
    end

    // Completion monitor: each done pulse consumes one expected rdata value.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            check("done_busy", busy, 1);
            check("done_req", mem_req, 0);
            if (exp_rdata.size() == 0) begin
                fail_now("unexpected_done", "done pulse with no transfer outstanding");
            end else begin
                check("rdata", rdata, exp_rdata.pop_front());
            end
        end
    end

    // Issues one transfer (called on a falling edge), queues its expectations and waits for done.
    task automatic do_xfer(input logic st, input logic [2:0] nb, input logic [ADDR_W-1:0] addr,
                           input logic [DW-1:0] wd, input int wait_cfg, input bit hold_start,
                           input int exp_lat);
        int            n;
        int            t0;
        int            waited;
        bit            seen;
        beat_t         b;
        logic [DW-1:0] want;

        fixed_wait = wait_cfg;
        waited = 0;
        while (busy !== 1'b0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (busy !== 1'b0) begin
            fail_now("idle_timeout", "sequencer never returned to idle");
            return;
        end

        start  = 1'b1;
        store  = st;
        nbytes = nb;
        nn     = addr;
        wdata  = wd;

        n    = (nb == 3'd0 || int'(nb) > MAXB) ? MAXB : int'(nb);
        want = '0;
        for (int i = 0; i < n; i++) begin
            b.addr  = addr + ADDR_W'(i);
            b.we    = st;
            b.wdata = st ? wd[8*i +: 8] : 8'h00;
            exp_beats.push_back(b);
            if (st) ref_mem[b.addr] = b.wdata;
            else    want[8*i +: 8] = ref_mem[b.addr];
        end
        exp_rdata.push_back(want);

        t0     = cyc;
        waited = 0;
        seen   = 1'b0;
        do begin
            @(negedge clk);
            waited++;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                start  = hold_start;
                store  = 1'($urandom);
                nbytes = 3'($urandom);
                nn     = ADDR_W'($urandom);
                wdata  = DW'($urandom);
            end
        end while (!seen && waited < 100);

        if (!seen) begin
            fail_now("done_timeout", "no done pulse within 100 cycles");
            start = 1'b0;
            return;
        end
        if (exp_lat >= 0) check("latency", 64'(cyc - t0), 64'(exp_lat));

        @(negedge clk);
        start = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_req", mem_req, 0);
        check("rdata_hold", rdata, want);
    endtask

    // Two-byte load aborted by reset right after its first byte is acknowledged.
    task automatic reset_mid_xfer();
        beat_t b;
        set_mem(16'h4000, 8'h77);
        set_mem(16'h4001, 8'h88);
        fixed_wait = 0;
        start  = 1'b1;
        store  = 1'b0;
        nbytes = 3'd2;
        nn     = 16'h4000;
        wdata  = '0;
        b.we = 1'b0; b.wdata = 8'h00;
        b.addr = 16'h4000; exp_beats.push_back(b);
        b.addr = 16'h4001; exp_beats.push_back(b);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst_pre_req", mem_req, 1);
        check("rst_pre_addr", mem_addr, 16'h4001);
        check("rst_pre_rdata", rdata, 32'h0000_0077);
        reset = 1'b1;
        @(negedge clk);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_done", done, 0);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            bus_mem[a] = 8'($urandom);
            ref_mem[a] = bus_mem[a];
        end

        // Reset wins over a simultaneous start and random acks.
        reset     = 1'b1;
        start     = 1'b1;
        store     = 1'b1;
        nbytes    = 3'd2;
        nn        = 16'h1234;
        wdata     = 32'hDEAD_BEEF;
        ack_noise = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_req", mem_req, 0);
        check("reset_we", mem_we, 0);
        check("reset_addr", mem_addr, 0);
        check("reset_wdata", mem_wdata, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rdata", rdata, 0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);

        // One-byte load, zero wait states.
        set_mem(16'h1234, 8'h5A);
        do_xfer(1'b0, 3'd1, 16'h1234, '0, 0, 1'b0, 2);

        // Two-byte load wrapping from the top of memory.
        set_mem(16'hFFFF, 8'hCD);
        set_mem(16'h0000, 8'hAB);
        do_xfer(1'b0, 3'd2, 16'hFFFF, '0, 0, 1'b0, 3);

        // Two-byte store with three wait states per byte.
        do_xfer(1'b1, 3'd2, 16'h8000, 32'h0000_BEEF, 3, 1'b0, 9);
        check("store_mem_lo", bus_mem[16'h8000], 8'hEF);
        check("store_mem_hi", bus_mem[16'h8001], 8'hBE);

        reset_mid_xfer();

        // start held high through XFER and DONE must not retrigger.
        do_xfer(1'b0, 3'd2, 16'h2000, '0, 0, 1'b1, 3);
        do_xfer(1'b1, 3'd3, 16'h2100, 32'h0012_3456, 1, 1'b1, 7);

        // Four-byte load crossing a page boundary.
        do_xfer(1'b0, 3'd4, 16'h00FE, '0, 0, 1'b0, 5);

        // Out-of-range byte counts become four-byte transfers.
        do_xfer(1'b0, 3'd0, 16'h3000, '0, 0, 1'b0, 5);
        do_xfer(1'b1, 3'd7, 16'hFFFE, 32'hCAFE_F00D, 0, 1'b0, 5);
        do_xfer(1'b0, 3'd5, 16'hFFFD, '0, 0, 1'b0, 5);

        // Randomised mix of loads and stores, counts, addresses and wait states.
        for (int i = 0; i < 40; i++) begin
            logic              st;
            logic [2:0]        nb;
            logic [ADDR_W-1:0] a;
            int                w;
            int                n;
            int                lat;
            st  = 1'($urandom);
            nb  = 3'($urandom);
            a   = ($urandom_range(0, 3) == 0) ? ADDR_W'(16'hFFFC + $urandom_range(0, 3))
                                              : ADDR_W'($urandom);
            w   = int'($urandom_range(0, 4));
            if (w == 4) w = -1;
            n   = (nb == 3'd0 || int'(nb) > MAXB) ? MAXB : int'(nb);
            lat = (w >= 0) ? n * (w + 1) + 1 : -1;
            do_xfer(st, nb, a, DW'($urandom), w, 1'($urandom), lat);
        end

        repeat (5) @(negedge clk);
        check("beats_left", 64'(exp_beats.size()), 0);
        check("dones_left", 64'(exp_rdata.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global bound on simulated time.
    initial begin
        #1000000;
        fail_now("watchdog", "simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/z80_ld_ind_nn_seq.md
Z80_LD_IND_NN_SEQ -- requirements
Module: z80_ld_ind_nn_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, the memory address width in bits.
REQ-002 SHALL have parameter MAX_BYTES, default 2, legal range 1..4, the largest transfer (1 = LD A,(nn); 2 = LD rr,(nn) and LD (nn),rr).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request a transfer; sampled only in IDLE.
REQ-006 SHALL have port store, input, 1 bit: 0 = load (memory to register), 1 = store (register to memory).
REQ-007 SHALL have port nbytes, input, 3 bits: byte count, legal range 1..MAX_BYTES.
REQ-008 SHALL have port nn, input, ADDR_W bits: first byte address (operand nn, already decoded).
REQ-009 SHALL have port wdata, input, 8*MAX_BYTES bits: store data, little-endian.
REQ-010 SHALL have port mem_req, output, 1 bit: bus request.
REQ-011 SHALL have port mem_we, output, 1 bit: write strobe, qualified by mem_req.
REQ-012 SHALL have port mem_addr, output, ADDR_W bits: bus address.
REQ-013 SHALL have port mem_wdata, output, 8 bits: bus write byte.
REQ-014 SHALL have port mem_ack, input, 1 bit: bus completes the current byte in this cycle.
REQ-015 SHALL have port mem_rdata, input, 8 bits: read byte, valid when mem_ack is high.
REQ-016 SHALL have port busy, output, 1 bit: high in XFER and DONE.
REQ-017 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-018 SHALL have port rdata, output, 8*MAX_BYTES bits: assembled load data, little-endian.

Function
REQ-019 SHALL implement states IDLE, XFER and DONE.
REQ-020 In IDLE with start=1 at cycle t, SHALL latch store, nbytes, nn and wdata, clear rdata, and enter XFER at t+1.
REQ-021 In XFER SHALL drive mem_req=1, mem_we=store, and mem_addr = (nn + k) mod 2^ADDR_W, where k is the byte index starting at 0.
REQ-022 mem_addr SHALL wrap modulo 2^ADDR_W; with nn=16'hFFFF the second byte SHALL be at 16'h0000.
REQ-023 For a store, mem_wdata SHALL equal latched wdata[8k+7:8k]; for a load, mem_wdata SHALL be 0.
REQ-024 All mem_* outputs SHALL hold stable until mem_ack=1; any number of wait cycles SHALL be tolerated.
REQ-025 On mem_ack=1 in a load, mem_rdata SHALL be written into rdata[8k+7:8k].
REQ-026 On mem_ack=1 with k < nbytes-1, k SHALL increment, mem_req SHALL stay high, and the new address SHALL appear the next cycle.
REQ-027 On mem_ack=1 with k = nbytes-1, SHALL enter DONE.
REQ-028 In DONE SHALL drive done=1 and mem_req=0, and SHALL return to IDLE next cycle.
REQ-029 start SHALL be ignored in XFER and DONE.
REQ-030 Latency with zero wait states: start at t, bytes acked at t+1..t+N, done at t+N+1, next start accepted at t+N+2.
REQ-031 rdata SHALL hold its value from DONE until the next accepted start; lanes at index nbytes and above SHALL be 0.
REQ-032 For a store, rdata SHALL remain 0.
REQ-033 nbytes=0 or nbytes>MAX_BYTES SHALL be treated as MAX_BYTES.
REQ-034 mem_ack while mem_req=0 SHALL be ignored.

Reset
REQ-035 reset=1 SHALL force IDLE, with mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, rdata=0 and k=0 at the next edge.
REQ-036 reset during XFER SHALL abort the transfer with no done pulse, and mem_req SHALL be low in the following cycle.
REQ-037 reset SHALL take priority over start and mem_ack in the same cycle.

Structure
REQ-038 A shared package z80_ld_pkg SHALL hold the state enum (IDLE, XFER, DONE) and the MAX_BYTES legal-range constants.
REQ-039 The block SHALL be a single module with no sub-module; the byte index and lane select SHALL be internal.

Verification
REQ-040 Load, 1 byte: nn=16'h1234, memory[16'h1234]=8'h5A, zero wait -> mem_addr 16'h1234 at t+1, done at t+2, rdata=16'h005A.
REQ-041 Load, 2 bytes, wrap: nn=16'hFFFF, memory[FFFF]=8'hCD, memory[0000]=8'hAB -> addresses FFFF then 0000, rdata=16'hABCD.
REQ-042 Store, 2 bytes: wdata=16'hBEEF, nn=16'h8000, 3 wait cycles per byte -> mem_we=1, writes 8'hEF at 8000 and 8'hBE at 8001, done at t+9.
REQ-043 Reset mid-transfer: reset asserted after the first ack of a 2-byte load -> mem_req=0 the next cycle, no done pulse, rdata=0.
REQ-044 start asserted in XFER and in DONE -> ignored; exactly one done pulse per accepted start.
REQ-045 MAX_BYTES=4, nbytes=4, nn=16'h00FE -> addresses 00FE, 00FF, 0100, 0101, done at t+5.
